puf_response_engine: RTL and testbench
======================================

Name: puf_response_engine

Overview:
- Measurement and response stage directly downstream of the ring-oscillator banks and their 32:1 select muxes.
- Drives the challenge select lines to two oscillator banks (A and B).
- Counts rising edges of each selected oscillator over a fixed clk-timed gate window and compares the two counts to produce one response bit per challenge.
- Sweeps RESP_BITS consecutive challenges, then presents a RESP_BITS-wide response with a tie mask, using a start/busy/done handshake.

Parameters:
- SEL_W, 5, width of the oscillator select / challenge.
- CNT_W, 16, width of each edge counter (saturating).
- GATE_CYCLES, 1024, clk cycles per measurement window (>=2).
- SETTLE_CYCLES, 8, clk cycles after a select change before counting starts (>=1).
- RESP_BITS, 8, number of response bits per run (1..2**SEL_W).
- PAIR_XOR, 5'b10101, XOR mask deriving the bank-B select from the bank-A select.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-high despite the name: 1 = reset.
- start  in  1  request a run. Sampled only in IDLE.
- challenge  in  SEL_W  base challenge. Latched when start is accepted.
- ro_a  in  1  selected bank-A oscillator output. Asynchronous to clk.
- ro_b  in  1  selected bank-B oscillator output. Asynchronous to clk.
- sel_a  out  SEL_W  bank-A mux select.
- sel_b  out  SEL_W  bank-B mux select.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the response is complete.
- response  out  RESP_BITS  response; bit i is the result of challenge i.
- tie_mask  out  RESP_BITS  bit i = 1 when the two counts for challenge i were equal.
- resp_valid  out  1  high from done until the next accepted start or reset.

Behaviour:
- Reset (rst_n=1 at a clk edge): state=IDLE. All outputs 0: sel_a, sel_b, busy, done, response, tie_mask, resp_valid. Counters, synchronisers and bit index are cleared. Reset has priority over every other event, including mid-run; a reset mid-run discards the partial response.
- Each ro input passes through a 2-flop synchroniser plus an edge-detect flop. A rising edge is flagged when the sync output is 1 and the previous value was 0.
- Counters: cleared on entry to SETTLE. They increment by 1 on a flagged edge only in MEASURE cycles, and saturate at 2**CNT_W-1 with no wrap.
- FSM states and transitions:
  - IDLE: start=1 latches challenge into base, sets idx=0, clears response, tie_mask and resp_valid, and goes to SETTLE. start while not in IDLE is ignored.
  - SETTLE: sel_a = base+idx, truncated to SEL_W so it wraps mod 2**SEL_W. sel_b = sel_a ^ PAIR_XOR. Stays SETTLE_CYCLES cycles, then goes to MEASURE.
  - MEASURE: GATE_CYCLES cycles of counting, then COMPARE.
  - COMPARE (1 cycle): response[idx] = (cnt_a > cnt_b); tie_mask[idx] = (cnt_a == cnt_b). If idx == RESP_BITS-1, go to DONE; else idx++ and go to SETTLE.
  - DONE (1 cycle): done=1, resp_valid=1, then IDLE. busy drops in the IDLE cycle.
- sel_a and sel_b hold their last values in IDLE and DONE.
- Edges still inside the synchroniser when MEASURE ends are not counted.
- Latency: done asserts exactly RESP_BITS*(SETTLE_CYCLES+GATE_CYCLES+1)+1 cycles after the cycle in which start is accepted.

Decomposition:
- Package puf_pkg holds:
  - the state enum (IDLE, SETTLE, MEASURE, COMPARE, DONE);
  - the SEL_W default and the PAIR_XOR default constant.
- Sub-module ro_edge_counter holds the synchroniser, edge detect and saturating CNT_W counter, with clear and enable inputs. It is instantiated twice, once for bank A and once for bank B.

Test Plan:
- Common parameters for all tests: GATE_CYCLES=16, SETTLE_CYCLES=2, RESP_BITS=4, challenge=0.
- Basic ordering: ro_a toggles every clk (8 edges per gate), ro_b toggles every 2 clks (4 edges) -> response=4'hF, tie_mask=0. done occurs exactly 77 cycles after start, with one-cycle width.
- Reversed ordering: ro_a and ro_b rates swapped -> response=4'h0, tie_mask=4'h0.
- Ties and saturation:
  - ro_a and ro_b identical -> response=0, tie_mask=4'hF.
  - With CNT_W=3, ro_a at 8 edges and ro_b at 4 -> cnt_a saturates at 7; response=4'hF.
- Select sweep and wrap: challenge=5'd30 -> sel_a sequence 30, 31, 0, 1. sel_b = sel_a ^ 5'b10101 at every step.
- Reset and start handling:
  - rst_n=1 during the MEASURE of bit 2 -> next cycle state=IDLE, all outputs 0.
  - A fresh start after reset yields a full, correct 4-bit response.
  - start pulsed while busy is ignored: no restart, and the challenge is not relatched.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF response engine.
// State encoding and oscillator pairing constants.
package puf_pkg;

    localparam int SEL_W_DEF = 5;
    localparam logic [SEL_W_DEF-1:0] PAIR_XOR_DEF = 5'b10101;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        COMPARE,
        DONE
    } state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one ring-oscillator output and counts its rising edges.
// Counter saturates at all-ones; clr wins over counting.
module ro_edge_counter
    import puf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic s1;
    logic s2;
    logic prev;
    logic rise;

    assign rise = s2 & ~prev;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= ro;
            s2   <= s1;
            prev <= s2;
            if (clr)
                cnt <= '0;
            else if (en && rise && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/puf_response_engine.sv
// Sweeps RESP_BITS challenges over two oscillator banks and compares
// gated edge counts to build a response word with a tie mask.
module puf_response_engine
    import puf_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int CNT_W = 16,
    parameter int GATE_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 8,
    parameter int RESP_BITS = 8,
    parameter logic [SEL_W-1:0] PAIR_XOR = SEL_W'(PAIR_XOR_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic [RESP_BITS-1:0] tie_mask,
    output logic                 resp_valid
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ?
                             GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_END = TMR_W'(GATE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);

    state_t state;
    state_t state_nx;

    logic [TMR_W-1:0] tmr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] sel_nx;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             cnt_clr;
    logic             cnt_en;
    logic             last;

    assign last    = (idx == IDX_LAST);
    assign idx_inc = idx + IDX_W'(1);
    assign sel_nx  = base + SEL_W'(idx_inc);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_a),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_b),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt_b)
    );

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = SETTLE;
            end
            SETTLE: begin
                cnt_clr = 1'b1;
                if (tmr == SETTLE_END)
                    state_nx = MEASURE;
            end
            MEASURE: begin
                cnt_en = 1'b1;
                if (tmr == GATE_END)
                    state_nx = COMPARE;
            end
            COMPARE: state_nx = last ? DONE : SETTLE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            tmr        <= '0;
            idx        <= '0;
            base       <= '0;
            sel_a      <= '0;
            sel_b      <= '0;
            response   <= '0;
            tie_mask   <= '0;
            resp_valid <= 1'b0;
        end else begin
            state <= state_nx;
            tmr   <= (state_nx == state) ? tmr + TMR_W'(1) : '0;
            if (state == IDLE && start) begin
                base       <= challenge;
                idx        <= '0;
                sel_a      <= challenge;
                sel_b      <= challenge ^ PAIR_XOR;
                response   <= '0;
                tie_mask   <= '0;
                resp_valid <= 1'b0;
            end
            if (state == COMPARE) begin
                response[idx] <= (cnt_a > cnt_b);
                tie_mask[idx] <= (cnt_a == cnt_b);
                if (last) begin
                    resp_valid <= 1'b1;
                end else begin
                    idx   <= idx_inc;
                    sel_a <= sel_nx;
                    sel_b <= sel_nx ^ PAIR_XOR;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_response_engine.sv
// Bench for puf_response_engine: two instances (16-bit and 3-bit
// counters) checked every cycle against a timeline model.
module tb_puf_response_engine;

    localparam int N = 4;
    localparam int S = 2;
    localparam int G = 16;
    localparam int P = S + G + 1;
    localparam int H = 4096;
    localparam logic [4:0] PX = 5'b10101;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic [4:0] challenge = '0;
    logic ro_a = 1'b0;
    logic ro_b = 1'b0;

    logic [4:0] sel_a16, sel_b16, sel_a3, sel_b3;
    logic busy16, done16, rv16, busy3, done3, rv3;
    logic [3:0] resp16, tie16, resp3, tie3;
    logic [20:0] o16, o3;

    assign o16 = {sel_a16, sel_b16, busy16, done16, rv16, resp16, tie16};
    assign o3  = {sel_a3, sel_b3, busy3, done3, rv3, resp3, tie3};

    puf_response_engine #(
        .CNT_W(16), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .RESP_BITS(N)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a16), .sel_b(sel_b16),
        .busy(busy16), .done(done16), .response(resp16),
        .tie_mask(tie16), .resp_valid(rv16)
    );

    puf_response_engine #(
        .CNT_W(3), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .RESP_BITS(N)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a3), .sel_b(sel_b3),
        .busy(busy3), .done(done3), .response(resp3),
        .tie_mask(tie3), .resp_valid(rv3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Oscillator stimulus, changed away from the sampling edge.
    int mode = 0;
    int tick = 0;
    always @(negedge clk) begin
        tick++;
        case (mode)
            0: begin
                ro_a = ~ro_a;
                if (tick % 2 == 0) ro_b = ~ro_b;
            end
            1: begin
                ro_b = ~ro_b;
                if (tick % 2 == 0) ro_a = ~ro_a;
            end
            2: begin
                ro_a = ~ro_a;
                ro_b = ro_a;
            end
            default: begin
                ro_a = 1'($urandom % 2);
                ro_b = 1'($urandom % 2);
            end
        endcase
    end

    // Reference model: run timeline derived from the accept edge.
    int cyc = 0;
    bit [H-1:0] ha;
    bit [H-1:0] hb;
    bit active = 0;
    int t0 = 0;
    logic [4:0] base = '0;
    logic [4:0] m_sel = '0;
    logic [4:0] m_selb = '0;
    logic m_done = 1'b0;
    logic m_rv = 1'b0;
    logic [3:0] m_r16 = '0, m_t16 = '0, m_r3 = '0, m_t3 = '0;

    function automatic int edges(input bit isb, input int j);
        int n = 0;
        int e0 = t0 + j * P + S;
        for (int e = e0; e < e0 + G; e++) begin
            if (isb) begin
                if (hb[(e - 1) % H] && !hb[(e - 2) % H]) n++;
            end else begin
                if (ha[(e - 1) % H] && !ha[(e - 2) % H]) n++;
            end
        end
        return n;
    endfunction

    task automatic record(input int j);
        int na = edges(1'b0, j);
        int nb = edges(1'b1, j);
        int sa = (na > 7) ? 7 : na;
        int sb = (nb > 7) ? 7 : nb;
        m_r16[j] = (na > nb);
        m_t16[j] = (na == nb);
        m_r3[j]  = (sa > sb);
        m_t3[j]  = (sa == sb);
    endtask

    always @(posedge clk) begin
        int ph;
        cyc++;
        ha[cyc % H] = ro_a;
        hb[cyc % H] = ro_b;
        m_done = 1'b0;
        if (rst_n) begin
            active = 0;
            m_sel = '0; m_selb = '0; m_rv = 1'b0;
            m_r16 = '0; m_t16 = '0; m_r3 = '0; m_t3 = '0;
        end else if (active) begin
            ph = cyc - t0;
            if (ph >= P && ph % P == 0) record(ph / P - 1);
            if (ph < N * P) begin
                m_sel  = 5'(base + 5'(ph / P));
                m_selb = m_sel ^ PX;
            end else if (ph == N * P) begin
                m_done = 1'b1;
                m_rv = 1'b1;
            end else begin
                active = 0;
            end
        end else if (start) begin
            active = 1;
            t0 = cyc;
            base = challenge;
            m_sel = challenge;
            m_selb = challenge ^ PX;
            m_rv = 1'b0;
            m_r16 = '0; m_t16 = '0; m_r3 = '0; m_t3 = '0;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cycle16", 32'(o16),
                32'({m_sel, m_selb, active, m_done, m_rv, m_r16, m_t16}));
            chk("cycle3", 32'(o3),
                32'({m_sel, m_selb, active, m_done, m_rv, m_r3, m_t3}));
        end
    end

    logic [3:0] r16, t16, r3, t3;
    logic [4:0] sa[N];
    logic [4:0] sb[N];
    int lat;

    task automatic run(input logic [4:0] ch, input int md, input bit poke);
        int sc;
        int off;
        bit got = 0;
        mode = md;
        @(negedge clk);
        start = 1'b1;
        challenge = ch;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            off = cyc - sc - 1;
            if (off % P == 0 && off / P < N) begin
                sa[off / P] = sel_a16;
                sb[off / P] = sel_b16;
            end
            if (done16) begin
                got = 1;
                break;
            end
            if (poke && k == 30) begin
                start = 1'b1;
                challenge = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        lat = cyc - sc;
        r16 = resp16; t16 = tie16; r3 = resp3; t3 = tie3;
        @(negedge clk);
        chk("done_width", 32'(done16), 32'd0);
        chk("rv_hold", 32'(rv16), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out16", 32'(o16), 32'd0);
        chk("rst_out3", 32'(o3), 32'd0);
        rst_n = 1'b0;
        cmp_en = 1;

        run(5'd0, 0, 0);
        chk("basic_resp", 32'(r16), 32'hF);
        chk("basic_tie", 32'(t16), 32'h0);
        chk("basic_latency", 32'(lat), 32'd77);
        chk("sat_resp3", 32'(r3), 32'hF);

        run(5'd0, 1, 0);
        chk("rev_resp", 32'(r16), 32'h0);
        chk("rev_tie", 32'(t16), 32'h0);

        run(5'd0, 2, 0);
        chk("tie_resp", 32'(r16), 32'h0);
        chk("tie_mask", 32'(t16), 32'hF);
        chk("tie_mask3", 32'(t3), 32'hF);

        run(5'd30, 3, 0);
        chk("wrap_sel0", 32'(sa[0]), 32'd30);
        chk("wrap_sel1", 32'(sa[1]), 32'd31);
        chk("wrap_sel2", 32'(sa[2]), 32'd0);
        chk("wrap_sel3", 32'(sa[3]), 32'd1);
        for (int j = 0; j < N; j++)
            chk("wrap_selb", 32'(sb[j]), 32'(sa[j] ^ PX));

        run(5'd0, 0, 1);
        chk("poke_resp", 32'(r16), 32'hF);
        chk("poke_latency", 32'(lat), 32'd77);

        mode = 0;
        @(negedge clk);
        start = 1'b1;
        challenge = 5'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * P + S + 4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("midrst16", 32'(o16), 32'd0);
        chk("midrst3", 32'(o3), 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_idle", 32'(busy16), 32'd0);

        run(5'd0, 0, 0);
        chk("fresh_resp", 32'(r16), 32'hF);
        chk("fresh_tie", 32'(t16), 32'h0);

        for (int i = 0; i < 6; i++)
            run(5'($urandom % 32), 3, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
